// File: rtl/ter_intlv_ram.sv
// rtl/ter_intlv_ram.sv - soft-bit interleaver RAM: linear writes, permutation-ROM indexed reads
// Read path: addr issue -> ROM latency -> index capture/check -> data out (request to dout_vld = 3 edges).
module ter_intlv_ram #(
  parameter int DW      = 6,
  parameter int ADDRESS = 16,
  parameter int DEPTH   = 8192
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [DW-1:0]      din,
  input  logic               wen,
  input  logic [ADDRESS-1:0] enable,
  input  logic [ADDRESS-1:0] id_offset,
  input  logic [12:0]        m_len,
  input  logic               request,
  output logic [ADDRESS-1:0] rom_addr,
  input  logic [12:0]        rom_data,
  output logic [DW-1:0]      dout,
  output logic               dout_vld,
  output logic               idx_err,
  output logic               rd_drop,
  input  logic               err_clr
);

  logic [DW-1:0]      mem [DEPTH];

  logic               wr_en;
  logic               rd_acc;
  logic [ADDRESS-1:0] m_len_ext;

  logic [ADDRESS-1:0] rom_addr_q, rom_addr_d;
  logic               s0_vld_q, s0_vld_d;
  logic               s1_vld_q, s1_vld_d;
  logic               s2_vld_q, s2_vld_d;
  logic [12:0]        idx_q, idx_d;
  logic               in_rng_q, in_rng_d;
  logic [DW-1:0]      dout_q, dout_d;
  logic               dout_vld_q, dout_vld_d;
  logic               idx_err_q, idx_err_d;
  logic               rd_drop_q, rd_drop_d;

  assign m_len_ext = {{(ADDRESS-13){1'b0}}, m_len};

  always_comb begin
    wr_en      = wen && (enable < m_len_ext);
    rd_acc     = request && !wen;
    rom_addr_d = rd_acc ? (id_offset + enable) : rom_addr_q;
    s0_vld_d   = rd_acc;
    s1_vld_d   = s0_vld_q;
    s2_vld_d   = s1_vld_q;
    idx_d      = s1_vld_q ? rom_data : idx_q;
    in_rng_d   = s1_vld_q ? (rom_data < m_len) : in_rng_q;
    dout_vld_d = s2_vld_q;
    dout_d     = dout_q;
    if (s2_vld_q) begin
      dout_d = in_rng_q ? mem[idx_q] : '0;
    end
    // Clear first so a same-cycle set event overrides it.
    idx_err_d = idx_err_q;
    rd_drop_d = rd_drop_q;
    if (err_clr) begin
      idx_err_d = 1'b0;
      rd_drop_d = 1'b0;
    end
    if (s2_vld_q && !in_rng_q) idx_err_d = 1'b1;
    if (request && wen)        rd_drop_d = 1'b1;
  end

  // RAM is not reset; nonblocking write keeps a same-edge stage-2 read on the old data.
  always_ff @(posedge clk) begin
    if (wr_en) mem[enable[12:0]] <= din;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rom_addr_q <= '0;
      s0_vld_q   <= 1'b0;
      s1_vld_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      idx_q      <= '0;
      in_rng_q   <= 1'b0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      idx_err_q  <= 1'b0;
      rd_drop_q  <= 1'b0;
    end else begin
      rom_addr_q <= rom_addr_d;
      s0_vld_q   <= s0_vld_d;
      s1_vld_q   <= s1_vld_d;
      s2_vld_q   <= s2_vld_d;
      idx_q      <= idx_d;
      in_rng_q   <= in_rng_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      idx_err_q  <= idx_err_d;
      rd_drop_q  <= rd_drop_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign idx_err  = idx_err_q;
  assign rd_drop  = rd_drop_q;

endmodule

// File: tb/tb_ter_intlv_ram.sv
// tb/tb_ter_intlv_ram.sv - scoreboard bench for ter_intlv_ram
// ROM model is synchronous: rom_data follows rom_addr by one clock.
module tb_ter_intlv_ram;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [5:0]  din = '0;
  logic        wen = 1'b0;
  logic [15:0] enable = '0;
  logic [15:0] id_offset = '0;
  logic [12:0] m_len = '0;
  logic        request = 1'b0;
  logic [15:0] rom_addr;
  logic [12:0] rom_data = '0;
  logic [5:0]  dout;
  logic        dout_vld;
  logic        idx_err;
  logic        rd_drop;
  logic        err_clr = 1'b0;

  logic [12:0] rom_mem [65536];
  int          edge_cnt = 0;
  int          chk_cnt = 0;
  int          pass_cnt = 0;

  typedef struct {
    logic [5:0] d;
    int         e;
  } exp_t;
  exp_t sb[$];

  ter_intlv_ram dut (
    .clk(clk), .n_rst(n_rst), .din(din), .wen(wen), .enable(enable),
    .id_offset(id_offset), .m_len(m_len), .request(request),
    .rom_addr(rom_addr), .rom_data(rom_data), .dout(dout),
    .dout_vld(dout_vld), .idx_err(idx_err), .rd_drop(rd_drop), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    rom_data <= rom_mem[rom_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (dout_vld) begin
      if (sb.size() == 0) begin
        check("unexpected_dout_vld", 32'd1, 32'd0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        check("dout", {26'd0, dout}, {26'd0, x.d});
        check("latency", edge_cnt, x.e);
      end
    end
  end

  task automatic step(input logic w, input logic r, input logic [15:0] en, input logic [5:0] d);
    @(negedge clk);
    wen = w; request = r; enable = en; din = d;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 16'd0, 6'd0);
  endtask

  // Request sampled on the next edge; its output is due three edges after that.
  task automatic req(input logic [15:0] en, input logic [5:0] exp);
    exp_t x;
    step(1'b0, 1'b1, en, 6'd0);
    x.d = exp;
    x.e = edge_cnt + 4;
    sb.push_back(x);
  endtask

  initial begin
    int vld_seen;
    for (int i = 0; i < 65536; i++) rom_mem[i] = '0;

    repeat (3) @(negedge clk);
    check("rst_rom_addr", {16'd0, rom_addr}, 32'd0);
    check("rst_dout", {26'd0, dout}, 32'd0);
    check("rst_dout_vld", {31'd0, dout_vld}, 32'd0);
    check("rst_idx_err", {31'd0, idx_err}, 32'd0);
    check("rst_rd_drop", {31'd0, rd_drop}, 32'd0);
    n_rst = 1'b1;

    // Full frame of 432, reverse-order permutation, back-to-back reads.
    m_len = 13'h01b0;
    for (int i = 0; i < 432; i++) begin
      rom_mem[i] = 13'(431 - i);
      step(1'b1, 1'b0, 16'(i), 6'(i));
    end
    for (int i = 0; i < 432; i++) req(16'(i), 6'((431 - i) % 64));
    idle(5);

    id_offset = 16'h37ac;
    rom_mem[16'h37b1] = 13'd10;
    req(16'd5, 6'd10);
    idle(1);
    check("offset_rom_addr", {16'd0, rom_addr}, 32'h37b1);
    id_offset = 16'd0;
    idle(4);

    m_len = 13'h03cc;
    rom_mem[100] = 13'h03cc;
    req(16'd100, 6'd0);
    idle(4);
    check("idx_err_set", {31'd0, idx_err}, 32'd1);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    check("idx_err_clr", {31'd0, idx_err}, 32'd0);

    m_len = 13'h01b0;
    step(1'b1, 1'b1, 16'd20, 6'h2a);
    idle(4);
    check("rd_drop_set", {31'd0, rd_drop}, 32'd1);
    rom_mem[200] = 13'd20;
    req(16'd200, 6'h2a);
    idle(4);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    check("rd_drop_clr", {31'd0, rd_drop}, 32'd0);

    // Write to index 30 lands on the same edge the read of index 30 leaves stage 2.
    rom_mem[300] = 13'd30;
    rom_mem[301] = 13'd30;
    req(16'd300, 6'd30);
    idle(2);
    step(1'b1, 1'b0, 16'd30, 6'h11);
    idle(1);
    req(16'd301, 6'h11);
    idle(5);

    step(1'b0, 1'b1, 16'd40, 6'd0);
    @(negedge clk); request = 1'b0; n_rst = 1'b0;
    @(negedge clk); n_rst = 1'b1;
    vld_seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (dout_vld) vld_seen++;
    end
    check("rst_mid_no_vld", 32'(vld_seen), 32'd0);
    rom_mem[40] = 13'd12;
    req(16'd40, 6'd12);
    idle(5);

    m_len = 13'h15f1;
    step(1'b1, 1'b0, 16'h15f0, 6'h15);
    idle(1);
    m_len = 13'h15f0;
    step(1'b1, 1'b0, 16'h15f0, 6'h3f);
    idle(1);
    m_len = 13'h15f1;
    rom_mem[500] = 13'h15f0;
    req(16'd500, 6'h15);
    idle(1);

    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
